// File: rtl/seg_pkg.sv
// Shared types and default parameters for the multiplexed 7-segment scan controller.
package seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    localparam int unsigned DEF_NUM_DIGITS   = 4;
    localparam int unsigned DEF_REFRESH_DIV  = 50000;
    localparam int unsigned DEF_BLANK_CYCLES = 500;

    localparam int unsigned MAX_DIGITS = 8;
    localparam logic [MAX_DIGITS-1:0] DIGIT_OFF = '1;

endpackage

// File: rtl/seg_scan_timer.sv
// Per-slot cycle counter; strobes are registered one cycle ahead so they align with the count.
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = DEF_REFRESH_DIV,
    parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic blank_done,
    output logic slot_done
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (en) begin
            cnt_nxt = (cnt == SLOT_LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            blank_done <= (BLANK_LAST == '0);
            slot_done  <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            blank_done <= (cnt_nxt == BLANK_LAST);
            slot_done  <= (cnt_nxt == SLOT_LAST);
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Common-anode digit scanner with anti-ghost blanking, leading-zero suppression and
// frame-synchronous double-buffered updates.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int unsigned REFRESH_DIV  = DEF_REFRESH_DIV,
    parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lzs,
    output logic                    load_ack,
    output logic [3:0]              nibble_out,
    output logic [NUM_DIGITS-1:0]   digit_en_n,
    output logic                    frame_start
);

    localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
    localparam int unsigned DATA_W = 4 * NUM_DIGITS;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic                  run;
    state_t                state, state_nxt;
    logic [IDX_W-1:0]      idx, idx_nxt;
    logic [DATA_W-1:0]     sh_data, sh_data_nxt, pend_data;
    logic [NUM_DIGITS-1:0] sh_mask, sh_mask_nxt, pend_mask;
    logic                  sh_lzs, sh_lzs_nxt, pend_lzs;
    logic                  pend_valid, pend_valid_nxt;
    logic                  ack_nxt, fs_nxt;
    logic [NUM_DIGITS-1:0] dark, en_nxt;
    logic [3:0]            nib_nxt;
    logic                  upper_zero;
    logic                  blank_done, slot_done;
    logic                  blank_end, slot_end, frame_end;

    seg_scan_timer #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (run),
        .blank_done(blank_done),
        .slot_done (slot_done)
    );

    assign blank_end = run && (state == BLANK) && blank_done;
    assign slot_end  = run && (state == SHOW) && slot_done;
    assign frame_end = slot_end && (idx == IDX_LAST);

    // Next state, shadow update and the registered output values derived from them.
    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        sh_data_nxt    = sh_data;
        sh_mask_nxt    = sh_mask;
        sh_lzs_nxt     = sh_lzs;
        pend_valid_nxt = pend_valid;
        ack_nxt        = 1'b0;
        upper_zero     = 1'b1;
        dark           = '0;
        en_nxt         = NUM_DIGITS'(DIGIT_OFF);

        if (blank_end) begin
            state_nxt = SHOW;
        end
        if (slot_end) begin
            state_nxt = BLANK;
            idx_nxt   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end

        // A load landing on the frame boundary bypasses pending so no frame shows stale data.
        if (frame_end && load) begin
            sh_data_nxt    = data_in;
            sh_mask_nxt    = blank_mask;
            sh_lzs_nxt     = lzs;
            pend_valid_nxt = 1'b0;
            ack_nxt        = 1'b1;
        end else if (frame_end && pend_valid) begin
            sh_data_nxt    = pend_data;
            sh_mask_nxt    = pend_mask;
            sh_lzs_nxt     = pend_lzs;
            pend_valid_nxt = 1'b0;
            ack_nxt        = 1'b1;
        end else if (load) begin
            pend_valid_nxt = 1'b1;
        end

        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (sh_data_nxt[4*i +: 4] == 4'h0);
            dark[i]    = sh_mask_nxt[i] || (sh_lzs_nxt && upper_zero && (i != 0));
        end

        if ((state_nxt == SHOW) && !dark[idx_nxt]) begin
            en_nxt = ~(NUM_DIGITS'(1) << idx_nxt);
        end
        nib_nxt = sh_data_nxt[{idx_nxt, 2'b00} +: 4];
        fs_nxt  = !run || frame_end;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run         <= 1'b0;
            state       <= BLANK;
            idx         <= '0;
            sh_data     <= '0;
            sh_mask     <= '0;
            sh_lzs      <= 1'b0;
            pend_data   <= '0;
            pend_mask   <= '0;
            pend_lzs    <= 1'b0;
            pend_valid  <= 1'b0;
            load_ack    <= 1'b0;
            nibble_out  <= 4'h0;
            digit_en_n  <= NUM_DIGITS'(DIGIT_OFF);
            frame_start <= 1'b0;
        end else begin
            run         <= 1'b1;
            state       <= state_nxt;
            idx         <= idx_nxt;
            sh_data     <= sh_data_nxt;
            sh_mask     <= sh_mask_nxt;
            sh_lzs      <= sh_lzs_nxt;
            pend_valid  <= pend_valid_nxt;
            load_ack    <= ack_nxt;
            nibble_out  <= nib_nxt;
            digit_en_n  <= en_nxt;
            frame_start <= fs_nxt;
            if (load && !frame_end) begin
                pend_data <= data_in;
                pend_mask <= blank_mask;
                pend_lzs  <= lzs;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with 4 digits, 8-cycle slots and 2 blank cycles.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  blank_mask = '0;
    logic        lzs = 1'b0;
    logic        load_ack;
    logic [3:0]  nibble_out;
    logic [3:0]  digit_en_n;
    logic        frame_start;

    int vectors = 0;
    int miscompares = 0;
    int frame = 0;

    seg_scan_ctrl #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .data_in    (data_in),
        .blank_mask (blank_mask),
        .lzs        (lzs),
        .load_ack   (load_ack),
        .nibble_out (nibble_out),
        .digit_en_n (digit_en_n),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Checks ncyc cycles starting at a frame_start sample; optional loads at cycles ld_a / ld_b.
    task automatic run_frame(input int ncyc, input logic [15:0] exp_nib, input logic [3:0] lit,
                             input logic exp_ack, input int ld_a, input logic [15:0] da,
                             input int ld_b, input logic [15:0] db, input logic [3:0] mk,
                             input logic lz);
        logic [15:0] nib_v;
        logic [3:0]  en_exp;
        int d, cn;
        nib_v = exp_nib;
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) step();
            load = 1'b0;
            d  = c / 8;
            cn = c % 8;
            en_exp = (cn < 2 || !lit[d]) ? 4'hF : ~(4'b0001 << d);
            check($sformatf("f%0d c%0d digit_en_n", frame, c), 16'(digit_en_n), 16'(en_exp));
            check($sformatf("f%0d c%0d nibble_out", frame, c), 16'(nibble_out), 16'(nib_v[4*d +: 4]));
            check($sformatf("f%0d c%0d frame_start", frame, c), 16'(frame_start), 16'(c == 0));
            check($sformatf("f%0d c%0d load_ack", frame, c), 16'(load_ack), 16'(c == 0 && exp_ack));
            if (c == ld_a || c == ld_b) begin
                load       = 1'b1;
                data_in    = (c == ld_a) ? da : db;
                blank_mask = mk;
                lzs        = lz;
            end
        end
        if (ncyc == 32) begin
            step();
            load = 1'b0;
        end
        frame++;
    endtask

    initial begin
        repeat (3) step();
        check("reset digit_en_n", 16'(digit_en_n), 16'hF);
        check("reset nibble_out", 16'(nibble_out), 16'h0);
        check("reset load_ack", 16'(load_ack), 16'h0);
        check("reset frame_start", 16'(frame_start), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        run_frame(32, 16'h0000, 4'b1111, 1'b0, -1, 16'h0, -1, 16'h0, 4'b0000, 1'b0);
        run_frame(32, 16'h0000, 4'b1111, 1'b0, 10, 16'h1234, -1, 16'h0, 4'b0000, 1'b0);
        run_frame(32, 16'h1234, 4'b1111, 1'b1, 5, 16'h00A5, 20, 16'h0007, 4'b0000, 1'b0);
        run_frame(32, 16'h0007, 4'b1111, 1'b1, 3, 16'h0000, -1, 16'h0, 4'b0000, 1'b1);
        run_frame(32, 16'h0000, 4'b0001, 1'b1, 3, 16'h0305, -1, 16'h0, 4'b0000, 1'b1);
        run_frame(32, 16'h0305, 4'b0111, 1'b1, 31, 16'h9876, -1, 16'h0, 4'b0100, 1'b0);
        run_frame(32, 16'h9876, 4'b1011, 1'b1, -1, 16'h0, -1, 16'h0, 4'b0000, 1'b0);
        run_frame(32, 16'h9876, 4'b1011, 1'b0, -1, 16'h0, -1, 16'h0, 4'b0000, 1'b0);
        run_frame(13, 16'h9876, 4'b1011, 1'b0, 5, 16'h5555, -1, 16'h0, 4'b0000, 1'b0);

        #2;
        rst_n = 1'b0;
        #1;
        check("async reset digit_en_n", 16'(digit_en_n), 16'hF);
        check("async reset nibble_out", 16'(nibble_out), 16'h0);
        check("async reset load_ack", 16'(load_ack), 16'h0);
        check("async reset frame_start", 16'(frame_start), 16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        run_frame(32, 16'h0000, 4'b1111, 1'b0, -1, 16'h0, -1, 16'h0, 4'b0000, 1'b0);
        run_frame(32, 16'h0000, 4'b1111, 1'b0, -1, 16'h0, -1, 16'h0, 4'b0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
